// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 display timing constants and helpers.
// Used by vga_sync_gen and by pixel_gen and its map/character modules.
// Contents: default H/V timing values, total derivation, and sync-window
// bound functions that take the timing values as arguments, so
// parameterised users get the same arithmetic as the defaults.
package vga_timing_pkg;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;

    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    function automatic int unsigned timing_total(input int unsigned disp, input int unsigned front,
                                                 input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    function automatic int unsigned sync_first(input int unsigned disp, input int unsigned front);
        return disp + front;
    endfunction

    function automatic int unsigned sync_last(input int unsigned disp, input int unsigned front,
                                              input int unsigned sync);
        return disp + front + sync - 1;
    endfunction

    function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                       input int unsigned hi);
        return (val >= lo) && (val <= hi);
    endfunction

    localparam int unsigned VGA_H_TOTAL =
        timing_total(VGA_H_DISPLAY, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int unsigned VGA_V_TOTAL =
        timing_total(VGA_V_DISPLAY, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Output bundle of the display timing generator.
// master: driven by vga_sync_gen. slave: consumed by pixel_gen / game logic.
// Signals: p_tick (pixel strobe), x/y (raster position), video_on,
// hsync/vsync, line_start/frame_start strobes, frame_cnt.
interface vga_sync_gen_if #(
    parameter int unsigned SCREEN_WIDTH    = 10,
    parameter int unsigned FRAME_CNT_WIDTH = 8
);
    logic                       p_tick;
    logic [SCREEN_WIDTH-1:0]    x;
    logic [SCREEN_WIDTH-1:0]    y;
    logic                       video_on;
    logic                       hsync;
    logic                       vsync;
    logic                       line_start;
    logic                       frame_start;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/pixel_tick_div.sv
// Pixel-rate strobe generator: divides sys_clk by CLK_DIV.
// Ports: sys_clk, sys_rst_n (async, active-low), p_tick (one sys_clk wide,
// high when the divider count sits at CLK_DIV-1).
// With CLK_DIV=1 the count is fixed at 0 and p_tick is permanently high.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic p_tick
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    if (CLK_DIV < 1) begin : g_div_chk
        $error("pixel_tick_div: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Display timing generator for the VGA port and pixel_gen.
// Ports: sys_clk, sys_rst_n (async, active-low), vga (vga_sync_gen_if.master):
// p_tick, x, y, video_on, hsync, vsync, line_start, frame_start, frame_cnt.
// Counters reset to the last pixel of the frame so that the first pixel
// tick after reset produces a clean frame_start and lands on (0,0).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH    = 10,
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned H_DISPLAY       = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT         = VGA_H_FRONT,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BACK          = VGA_H_BACK,
    parameter int unsigned V_DISPLAY       = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT         = VGA_V_FRONT,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BACK          = VGA_V_BACK,
    parameter bit          SYNC_ACTIVE     = 1'b0,
    parameter int unsigned FRAME_CNT_WIDTH = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    vga_sync_gen_if.master vga
);
    localparam int unsigned H_TOTAL  = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL  = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HS_FIRST = sync_first(H_DISPLAY, H_FRONT);
    localparam int unsigned HS_LAST  = sync_last(H_DISPLAY, H_FRONT, H_SYNC);
    localparam int unsigned VS_FIRST = sync_first(V_DISPLAY, V_FRONT);
    localparam int unsigned VS_LAST  = sync_last(V_DISPLAY, V_FRONT, V_SYNC);

    localparam logic [SCREEN_WIDTH-1:0]    H_LAST    = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0]    V_LAST    = SCREEN_WIDTH'(V_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0]    CNT_ONE   = SCREEN_WIDTH'(1);
    localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = FRAME_CNT_WIDTH'(1);

    if (H_TOTAL > (1 << SCREEN_WIDTH)) begin : g_h_chk
        $error("vga_sync_gen: horizontal total does not fit in SCREEN_WIDTH");
    end
    if (V_TOTAL > (1 << SCREEN_WIDTH)) begin : g_v_chk
        $error("vga_sync_gen: vertical total does not fit in SCREEN_WIDTH");
    end

    logic                       p_tick;
    logic [SCREEN_WIDTH-1:0]    h;
    logic [SCREEN_WIDTH-1:0]    v;
    logic [SCREEN_WIDTH-1:0]    h_next;
    logic [SCREEN_WIDTH-1:0]    v_next;
    logic                       h_last;
    logic                       v_last;
    logic                       line_start;
    logic                       frame_start;
    logic                       hsync_q;
    logic                       vsync_q;
    logic                       video_on_q;
    logic                       frame_seen;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .p_tick    (p_tick)
    );

    always_comb begin
        h_last = (h == H_LAST);
        v_last = (v == V_LAST);
        h_next = h_last ? '0 : h + CNT_ONE;
        v_next = v;
        if (h_last) begin
            v_next = v_last ? '0 : v + CNT_ONE;
        end
    end

    assign line_start  = p_tick & h_last;
    assign frame_start = line_start & v_last;

    // Sync and blanking are decoded from the next-state counters so they
    // update on the same edge as x/y and never lag by a pixel.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h          <= H_LAST;
            v          <= V_LAST;
            hsync_q    <= ~SYNC_ACTIVE;
            vsync_q    <= ~SYNC_ACTIVE;
            video_on_q <= 1'b0;
        end else if (p_tick) begin
            h          <= h_next;
            v          <= v_next;
            hsync_q    <= in_window(32'(h_next), HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q    <= in_window(32'(v_next), VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on_q <= (32'(h_next) < H_DISPLAY) && (32'(v_next) < V_DISPLAY);
        end
    end

    // The frame_start that leaves reset closes no real frame, so it only
    // arms the counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_seen  <= 1'b0;
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_seen <= 1'b1;
            if (frame_seen) begin
                frame_cnt_q <= frame_cnt_q + FRAME_ONE;
            end
        end
    end

    assign vga.p_tick      = p_tick;
    assign vga.x           = h;
    assign vga.y           = v;
    assign vga.video_on    = video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;
    assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Display timing generator driving the VGA port and feeding pixel coordinates to `pixel_gen`. It divides `sys_clk` down to the pixel rate and scans horizontal and vertical counters over a 640x480@60 raster. It produces `x`, `y`, `video_on`, `hsync` and `vsync`, plus frame and line strobes that game logic uses to update state once per frame.

## Interface
Parameters:
- `SCREEN_WIDTH`, 10: width of the `x` and `y` outputs.
- `CLK_DIV`, 4: `sys_clk` cycles per pixel; must be ≥1. Default gives 100 MHz → 25 MHz.
- `H_DISPLAY`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing in pixels.
- `V_DISPLAY`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing in lines.
- `SYNC_ACTIVE`, 0: sync pulse polarity.
- `FRAME_CNT_WIDTH`, 8: width of the frame counter.

Ports:
- `sys_clk` input 1: system clock. One clock; reset is asynchronous and active-low.
- `sys_rst_n` input 1: asynchronous active-low reset.
- `p_tick` output 1: one-`sys_clk` pixel strobe.
- `x` output SCREEN_WIDTH: horizontal count.
- `y` output SCREEN_WIDTH: vertical count.
- `video_on` output 1: high while in the visible area.
- `hsync` output 1: horizontal sync to the VGA port.
- `vsync` output 1: vertical sync to the VGA port.
- `line_start` output 1: strobe announcing the next line.
- `frame_start` output 1: strobe announcing the next frame.
- `frame_cnt` output FRAME_CNT_WIDTH: frames completed, modulo 2^FRAME_CNT_WIDTH.

## Operation
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Elaboration fails if H_TOTAL or V_TOTAL exceeds 2^SCREEN_WIDTH.
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `p_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
  - With CLK_DIV=1, `p_tick` is constantly 1 after reset.
- Horizontal counter `h`: on `p_tick`, `h` increments; when `h` is H_TOTAL-1 it wraps to 0.
- Vertical counter `v`: on `p_tick` with `h` at H_TOTAL-1, `v` increments; when `v` is V_TOTAL-1 it wraps to 0.
- `x` = `h` and `y` = `v`, both registered.
- `hsync` is SYNC_ACTIVE while `h` ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751; otherwise `~SYNC_ACTIVE`.
- `vsync` is SYNC_ACTIVE while `v` ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491; otherwise `~SYNC_ACTIVE`.
- `video_on` = (`h` < H_DISPLAY) && (`v` < V_DISPLAY).
- `hsync`, `vsync` and `video_on` are registered from the next-state counter values, so they are always coherent with the current `x`/`y`.
- `line_start` = `p_tick` && `h`==H_TOTAL-1.
- `frame_start` = `line_start` && `v`==V_TOTAL-1.
- `frame_cnt` increments, wrapping, on each `frame_start`.

## Timing
- Reset values:
  - `div_cnt`=0.
  - `x`=H_TOTAL-1 (799), `y`=V_TOTAL-1 (524).
  - `video_on`=0.
  - `hsync`=`vsync`=`~SYNC_ACTIVE`.
  - `p_tick`=0 (for CLK_DIV>1).
  - `line_start`=`frame_start`=0.
  - `frame_cnt`=0.
- After reset release:
  - First `p_tick` is in cycle CLK_DIV-1 (cycle 3 by default).
  - `frame_start` and `line_start` pulse in that same cycle.
  - `frame_cnt` stays 0 on that first strobe (reset-exit frame not counted).
  - At the following edge, `x`,`y` = (0,0) and `video_on`=1.
- `x`, `y`, `video_on`, `hsync` and `vsync` change only on the `sys_clk` edge at which `p_tick` is sampled high. They are then stable for exactly CLK_DIV cycles.
- `pixel_gen` output is valid combinationally within that window.
- `line_start` and `frame_start` are 1 `sys_clk` wide, coincident with `p_tick`, once per line/frame.
- Period: line = H_TOTAL·CLK_DIV `sys_clk` cycles (3200); frame = 1,680,000 cycles.
- Asynchronous reset mid-frame immediately forces all reset values. The scan restarts with a fresh `frame_start`; no partial sync pulse is extended.

## Structure
- Shared package `vga_timing_pkg` holds the 640x480@60 timing constants, the H_TOTAL/V_TOTAL derivations and the sync-window bound functions. `pixel_gen` and its map/character modules reuse them.
- One sub-module, `pixel_tick_div`, contains the CLK_DIV counter and `p_tick` decode. It is reusable for other pixel-rate logic.

## Test plan
- Reset held, then released at t0 → `p_tick`, `frame_start` and `line_start` are high at cycle 3. `x`=0, `y`=0, `video_on`=1 at cycle 4. `x`=799, `y`=524 during reset.
- Run one line → `p_tick` every 4 cycles. `hsync` low for exactly 96 ticks starting at `x`=656. `video_on` falls at `x`=640. `line_start` once per 3200 cycles.
- Run two full frames → `vsync` low for `y`=490..491 (1600 pixel ticks). `frame_start` interval is 1,680,000 cycles. `frame_cnt` reaches 2.
- Assert `sys_rst_n` at `x`=700, `y`=300 (inside hsync) → `hsync` goes high asynchronously, counters reload 799/524, and the next `frame_start` is at cycle 3 after release.
- CLK_DIV=1, SYNC_ACTIVE=1 build → `p_tick` constantly 1 after reset. `x` advances every cycle. `hsync`/`vsync` are high only inside the sync windows.
- Run 256 frames with FRAME_CNT_WIDTH=8 → `frame_cnt` wraps 255→0 on the 256th counted `frame_start`.
